main_memory_arbiter: RTL
========================

Name: main_memory_arbiter

Overview:
- Shares the single main-memory read/write port between two requesters: instruction fetch and data load/store.
- Grants one request at a time and drives the memory address, write data and write enable.
- Counts the fixed memory read latency and returns read data, with a valid strobe, to the requester that issued the read.
- Sits between the CPU stage logic and main memory; it replaces stage-based address muxing with a req/grant handshake.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- READ_LATENCY, 1, cycles from the grant cycle to the cycle with valid mem_read_data. Legal range 1..4; any other value is an elaboration error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch requests a read.
- fetch_addr  in  ADDR_WIDTH  fetch read address.
- fetch_grant  out  1  fetch request accepted this cycle.
- fetch_rvalid  out  1  fetch_rdata valid this cycle.
- fetch_rdata  out  DATA_WIDTH  fetch read data.
- data_req  in  1  data port requests an access.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  ADDR_WIDTH  load/store address.
- data_wdata  in  DATA_WIDTH  store data.
- data_grant  out  1  data request accepted this cycle.
- data_rvalid  out  1  data_rdata valid this cycle.
- data_rdata  out  DATA_WIDTH  load data.
- mem_read_address  out  ADDR_WIDTH  to memory read port.
- mem_write_address  out  ADDR_WIDTH  to memory write port.
- mem_write_data  out  DATA_WIDTH  to memory write port.
- mem_write_enable  out  1  memory write strobe.
- mem_read_data  in  DATA_WIDTH  from memory.
- busy  out  1  a read is outstanding.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE, latency counter 0, latched address 0, last_grant = FETCH.
  - All grant, rvalid and write-enable outputs 0; all rdata outputs and memory address/data outputs 0.
  - A reset during WAIT aborts the read; no rvalid is ever issued for it.
- States: IDLE, WAIT.
- Arbitration is live in IDLE, and in the WAIT cycle where counter == 0 (the response cycle).
- Grants are combinational from state and the req inputs.
- Fixed priority: data over fetch.
- Grant cycle:
  - mem_read_address = granted address. This address is also latched.
  - A data store drives mem_write_enable = 1, mem_write_address = data_addr and mem_write_data = data_wdata for exactly this cycle. It completes immediately; the state stays IDLE and no rvalid follows.
  - A read (fetch, or data with data_we = 0) moves the state to WAIT with counter = READ_LATENCY-1 and records the owner.
- WAIT:
  - No new grant except in the response cycle.
  - mem_read_address holds the latched address.
  - The counter decrements every cycle until it reaches 0.
- Response cycle (WAIT, counter == 0):
  - The owner's rvalid = 1 and its rdata = mem_read_data.
  - With a new read granted in the same cycle, the state re-enters WAIT. Otherwise it returns to IDLE.
  - Back-to-back reads therefore issue every READ_LATENCY cycles.
- Between responses, rdata outputs hold the last returned value.
- rvalid is a one-cycle pulse, exactly one per granted read.
- Requester rules:
  - Hold req, addr, we and wdata stable until grant.
  - Dropping req before grant is legal; no grant is issued.
  - Req in the cycle after a grant is a new request.
- Simultaneous data_req and fetch_req: data wins; fetch is granted at the next arbitration point.
- busy = (state == WAIT).
- Idle with no request: mem_read_address holds the latched address and mem_write_enable = 0.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests, the requester that is not last_grant wins.
  - last_grant updates on every grant.
  - A single requester always wins.
- Not defined: fixed data-over-fetch priority; last_grant is unused.

Decomposition:
- Shared defines file (alongside the existing arch defines):
  - Arbiter state encodings ARB_IDLE and ARB_WAIT.
  - Requester IDs REQ_FETCH and REQ_DATA.
  - Maximum legal read latency constant, 4.
- One natural sub-module: read_latency_counter.
  - Ports: load, load value, done flag.
  - Provides load and decrement and flags counter == 0.
  - Reused by future multi-cycle memories.

Test Plan:
- Reset with READ_LATENCY = 1 → all outputs 0, busy = 0. Assert rst during WAIT → no rvalid follows.
- fetch_req with fetch_addr = 0x100 → fetch_grant in the same cycle, mem_read_address = 0x100. Next cycle: fetch_rvalid = 1, fetch_rdata = memory word 0x100.
- Both requesting, data_we = 0, data_addr = 0x200, fetch_addr = 0x104, fixed priority → data granted first; fetch granted in the data response cycle; fetch_rvalid arrives one cycle later.
- data store, data_addr = 0x40, data_wdata = 0xDEADBEEF → mem_write_enable is high for 1 cycle with those values. No rvalid. A following load of 0x40 returns 0xDEADBEEF.
- READ_LATENCY = 3, continuous fetch_req → grants every 3 cycles. busy is high between them. No grant is issued mid-WAIT.
- ARB_ROUND_ROBIN_EN, both requesting continuously → grants alternate data, fetch, data… (from reset, last_grant = FETCH, so data goes first).

Source files
------------

// File: rtl/main_memory_arbiter_pkg.sv
// main_memory_arbiter_pkg: arbiter state encodings, requester IDs and read latency limit
// shared by the main-memory arbiter and its latency counter.
package main_memory_arbiter_pkg;
   localparam logic ARB_IDLE = 1'b0;
   localparam logic ARB_WAIT = 1'b1;
   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_DATA = 1'b1;
   localparam int MAX_READ_LATENCY = 4;
endpackage

// File: rtl/main_memory_arbiter_read_latency_counter.sv
// main_memory_arbiter_read_latency_counter: loadable down-counter that stops at zero and flags it.
module main_memory_arbiter_read_latency_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);
   logic [WIDTH-1:0] count;
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else count <= load ? load_value : (done ? count : count - WIDTH'(1));
   assign done = count == '0;
endmodule

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter: req/grant arbiter sharing one main-memory port between fetch and data.
// Define ARB_ROUND_ROBIN_EN to alternate winners on simultaneous requests instead of data-first.
module main_memory_arbiter
   import main_memory_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_grant,
   output logic                  fetch_rvalid,
   output logic [DATA_WIDTH-1:0] fetch_rdata,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0] data_wdata,
   output logic                  data_grant,
   output logic                  data_rvalid,
   output logic [DATA_WIDTH-1:0] data_rdata,
   output logic [ADDR_WIDTH-1:0] mem_read_address,
   output logic [ADDR_WIDTH-1:0] mem_write_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  mem_write_enable,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  busy
);
   localparam int CW = $clog2(MAX_READ_LATENCY);
   localparam logic [CW-1:0] LOAD_VALUE = CW'(READ_LATENCY - 1);
   if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
      $error("READ_LATENCY must be in 1..%0d", MAX_READ_LATENCY);
   end
   logic state, owner, done, live, pick_data, grant, read_grant;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] fetch_rdata_q, data_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant;
   always_comb pick_data = data_req && (!fetch_req || last_grant == REQ_FETCH);
   always_ff @(posedge clk or posedge rst)
      if (rst) last_grant <= REQ_FETCH;
      else if (grant) last_grant <= data_grant ? REQ_DATA : REQ_FETCH;
`else
   always_comb pick_data = data_req;
`endif
   // the counter idles at zero, so done also marks the response cycle while waiting
   always_comb begin
      live = !rst && (state == ARB_IDLE || done);
      data_grant = live && pick_data;
      fetch_grant = live && fetch_req && !pick_data;
      grant = data_grant || fetch_grant;
      read_grant = fetch_grant || (data_grant && !data_we);
      mem_read_address = data_grant ? data_addr : (fetch_grant ? fetch_addr : addr_q);
      mem_write_enable = data_grant && data_we;
      mem_write_address = mem_write_enable ? data_addr : '0;
      mem_write_data = mem_write_enable ? data_wdata : '0;
      busy = state == ARB_WAIT;
      fetch_rvalid = busy && done && owner == REQ_FETCH;
      data_rvalid = busy && done && owner == REQ_DATA;
      fetch_rdata = fetch_rvalid ? mem_read_data : fetch_rdata_q;
      data_rdata = data_rvalid ? mem_read_data : data_rdata_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= ARB_IDLE;
         owner <= REQ_FETCH;
         addr_q <= '0;
         fetch_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state <= read_grant ? ARB_WAIT : (done ? ARB_IDLE : state);
         if (read_grant) owner <= data_grant ? REQ_DATA : REQ_FETCH;
         if (grant) addr_q <= mem_read_address;
         if (fetch_rvalid) fetch_rdata_q <= mem_read_data;
         if (data_rvalid) data_rdata_q <= mem_read_data;
      end
   main_memory_arbiter_read_latency_counter #(.WIDTH(CW)) u_latency (
      .clk(clk),
      .rst(rst),
      .load(read_grant),
      .load_value(LOAD_VALUE),
      .done(done)
   );
endmodule
